// File: rtl/xbar_pkg.sv
// Shared types and address map defaults for the axi_xbar_1to2 crossbar.
// Target TGT_ERR is only ever produced when AXI_XBAR_DECERR_EN is defined.
package xbar_pkg;

  typedef enum logic [1:0] {
    TGT_MEM,
    TGT_UART,
    TGT_ERR
  } target_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP
  } wr_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] UART_BASE_DEF = 32'ha00003f8;
  localparam logic [31:0] UART_SIZE_DEF = 32'h00000008;
  localparam logic [31:0] MEM_BASE_DEF  = 32'h80000000;
  localparam logic [31:0] MEM_SIZE_DEF  = 32'h08000000;

endpackage

// File: rtl/axi_addr_decode.sv
// Combinational address decoder: maps a byte address onto a crossbar target.
// With AXI_XBAR_DECERR_EN defined, addresses outside both regions map to TGT_ERR.
module axi_addr_decode
  import xbar_pkg::*;
#(
  parameter logic [31:0] UART_BASE = UART_BASE_DEF,
  parameter logic [31:0] UART_SIZE = UART_SIZE_DEF,
  parameter logic [31:0] MEM_BASE  = MEM_BASE_DEF,
  parameter logic [31:0] MEM_SIZE  = MEM_SIZE_DEF
) (
  input  logic [31:0] addr_i,
  output target_e     target_o
);

  // 33-bit bounds so that base+size at the top of the address space cannot wrap
  logic [32:0] addr_ext;
  logic [32:0] uart_lo;
  logic [32:0] uart_hi;
  logic [32:0] mem_lo;
  logic [32:0] mem_hi;
  logic        uart_hit;
  logic        mem_hit;

  assign addr_ext = {1'b0, addr_i};
  assign uart_lo  = {1'b0, UART_BASE};
  assign uart_hi  = {1'b0, UART_BASE} + {1'b0, UART_SIZE};
  assign mem_lo   = {1'b0, MEM_BASE};
  assign mem_hi   = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

  assign uart_hit = (addr_ext >= uart_lo) && (addr_ext < uart_hi);
  assign mem_hit  = (addr_ext >= mem_lo) && (addr_ext < mem_hi);

`ifdef AXI_XBAR_DECERR_EN
  always_comb begin
    if (uart_hit) begin
      target_o = TGT_UART;
    end else if (mem_hit) begin
      target_o = TGT_MEM;
    end else begin
      target_o = TGT_ERR;
    end
  end
`else
  // Without the error target everything that is not UART falls through to memory
  logic unused_mem_hit;
  assign unused_mem_hit = mem_hit;
  assign target_o = uart_hit ? TGT_UART : TGT_MEM;
`endif

endmodule

// File: rtl/axi_xbar_1to2.sv
// AXI4-Lite 1-master to 2-slave crossbar (slave 0 memory, slave 1 UART), zero-latency routing.
// Define AXI_XBAR_DECERR_EN to answer unmapped addresses locally with DECERR.
module axi_xbar_1to2
  import xbar_pkg::*;
#(
  parameter logic [31:0] UART_BASE = UART_BASE_DEF,
  parameter logic [31:0] UART_SIZE = UART_SIZE_DEF,
  parameter logic [31:0] MEM_BASE  = MEM_BASE_DEF,
  parameter logic [31:0] MEM_SIZE  = MEM_SIZE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  // upstream master
  input  logic [31:0] m_awaddr_i,
  input  logic        m_awvalid_i,
  output logic        m_awready_o,
  input  logic [31:0] m_wdata_i,
  input  logic [3:0]  m_wstrb_i,
  input  logic        m_wvalid_i,
  output logic        m_wready_o,
  output logic [1:0]  m_bresp_o,
  output logic        m_bvalid_o,
  input  logic        m_bready_i,
  input  logic [31:0] m_araddr_i,
  input  logic        m_arvalid_i,
  output logic        m_arready_o,
  output logic [31:0] m_rdata_o,
  output logic [1:0]  m_rresp_o,
  output logic        m_rvalid_o,
  input  logic        m_rready_i,
  // slave 0: memory
  output logic [31:0] s_mem_awaddr_o,
  output logic        s_mem_awvalid_o,
  input  logic        s_mem_awready_i,
  output logic [31:0] s_mem_wdata_o,
  output logic [3:0]  s_mem_wstrb_o,
  output logic        s_mem_wvalid_o,
  input  logic        s_mem_wready_i,
  input  logic [1:0]  s_mem_bresp_i,
  input  logic        s_mem_bvalid_i,
  output logic        s_mem_bready_o,
  output logic [31:0] s_mem_araddr_o,
  output logic        s_mem_arvalid_o,
  input  logic        s_mem_arready_i,
  input  logic [31:0] s_mem_rdata_i,
  input  logic [1:0]  s_mem_rresp_i,
  input  logic        s_mem_rvalid_i,
  output logic        s_mem_rready_o,
  // slave 1: UART
  output logic [31:0] s_uart_awaddr_o,
  output logic        s_uart_awvalid_o,
  input  logic        s_uart_awready_i,
  output logic [31:0] s_uart_wdata_o,
  output logic [3:0]  s_uart_wstrb_o,
  output logic        s_uart_wvalid_o,
  input  logic        s_uart_wready_i,
  input  logic [1:0]  s_uart_bresp_i,
  input  logic        s_uart_bvalid_i,
  output logic        s_uart_bready_o,
  output logic [31:0] s_uart_araddr_o,
  output logic        s_uart_arvalid_o,
  input  logic        s_uart_arready_i,
  input  logic [31:0] s_uart_rdata_i,
  input  logic [1:0]  s_uart_rresp_i,
  input  logic        s_uart_rvalid_i,
  output logic        s_uart_rready_o
);

  rd_state_e r_state_q, r_state_d;
  target_e   r_tgt_q, r_tgt_d;
  wr_state_e w_state_q, w_state_d;
  target_e   w_tgt_q, w_tgt_d;

  target_e   ar_tgt;
  target_e   aw_tgt;
  target_e   wr_sel;
  logic      aw_route;
  logic      w_route;
  logic      b_route;
  logic      ar_hs;
  logic      r_hs;
  logic      aw_hs;
  logic      w_hs;
  logic      b_hs;

  axi_addr_decode #(
    .UART_BASE(UART_BASE),
    .UART_SIZE(UART_SIZE),
    .MEM_BASE (MEM_BASE),
    .MEM_SIZE (MEM_SIZE)
  ) u_ar_decode (
    .addr_i  (m_araddr_i),
    .target_o(ar_tgt)
  );

  axi_addr_decode #(
    .UART_BASE(UART_BASE),
    .UART_SIZE(UART_SIZE),
    .MEM_BASE (MEM_BASE),
    .MEM_SIZE (MEM_SIZE)
  ) u_aw_decode (
    .addr_i  (m_awaddr_i),
    .target_o(aw_tgt)
  );

  assign ar_hs = m_arvalid_i && m_arready_o;
  assign r_hs  = m_rvalid_o && m_rready_i;
  assign aw_hs = m_awvalid_i && m_awready_o;
  assign w_hs  = m_wvalid_i && m_wready_o;
  assign b_hs  = m_bvalid_o && m_bready_i;

  // Read routing: AR follows the live decode in R_IDLE, R follows the latched target
  always_comb begin
    m_arready_o      = 1'b0;
    m_rvalid_o       = 1'b0;
    m_rdata_o        = '0;
    m_rresp_o        = RESP_OKAY;
    s_mem_araddr_o   = '0;
    s_mem_arvalid_o  = 1'b0;
    s_mem_rready_o   = 1'b0;
    s_uart_araddr_o  = '0;
    s_uart_arvalid_o = 1'b0;
    s_uart_rready_o  = 1'b0;
    if (!rst) begin
      if (r_state_q == R_IDLE) begin
        case (ar_tgt)
          TGT_MEM: begin
            s_mem_araddr_o  = m_araddr_i;
            s_mem_arvalid_o = m_arvalid_i;
            m_arready_o     = s_mem_arready_i;
          end
          TGT_UART: begin
            s_uart_araddr_o  = m_araddr_i;
            s_uart_arvalid_o = m_arvalid_i;
            m_arready_o      = s_uart_arready_i;
          end
          default: m_arready_o = 1'b1;
        endcase
      end else begin
        case (r_tgt_q)
          TGT_MEM: begin
            m_rvalid_o     = s_mem_rvalid_i;
            m_rdata_o      = s_mem_rdata_i;
            m_rresp_o      = s_mem_rresp_i;
            s_mem_rready_o = m_rready_i;
          end
          TGT_UART: begin
            m_rvalid_o      = s_uart_rvalid_i;
            m_rdata_o       = s_uart_rdata_i;
            m_rresp_o       = s_uart_rresp_i;
            s_uart_rready_o = m_rready_i;
          end
          default: begin
            m_rvalid_o = 1'b1;
            m_rresp_o  = RESP_DECERR;
          end
        endcase
      end
    end
  end

  // W is only let through in W_IDLE alongside a valid AW so both go to the same slave
  assign wr_sel   = (w_state_q == W_IDLE) ? aw_tgt : w_tgt_q;
  assign aw_route = !rst && ((w_state_q == W_IDLE) || (w_state_q == W_ADDR));
  assign w_route  = !rst && (((w_state_q == W_IDLE) && m_awvalid_i) || (w_state_q == W_DATA));
  assign b_route  = !rst && (w_state_q == W_RESP);

  always_comb begin
    m_awready_o      = 1'b0;
    m_wready_o       = 1'b0;
    m_bvalid_o       = 1'b0;
    m_bresp_o        = RESP_OKAY;
    s_mem_awaddr_o   = '0;
    s_mem_awvalid_o  = 1'b0;
    s_mem_wdata_o    = '0;
    s_mem_wstrb_o    = '0;
    s_mem_wvalid_o   = 1'b0;
    s_mem_bready_o   = 1'b0;
    s_uart_awaddr_o  = '0;
    s_uart_awvalid_o = 1'b0;
    s_uart_wdata_o   = '0;
    s_uart_wstrb_o   = '0;
    s_uart_wvalid_o  = 1'b0;
    s_uart_bready_o  = 1'b0;
    if (aw_route) begin
      case (wr_sel)
        TGT_MEM: begin
          s_mem_awaddr_o  = m_awaddr_i;
          s_mem_awvalid_o = m_awvalid_i;
          m_awready_o     = s_mem_awready_i;
        end
        TGT_UART: begin
          s_uart_awaddr_o  = m_awaddr_i;
          s_uart_awvalid_o = m_awvalid_i;
          m_awready_o      = s_uart_awready_i;
        end
        default: m_awready_o = 1'b1;
      endcase
    end
    if (w_route) begin
      case (wr_sel)
        TGT_MEM: begin
          s_mem_wdata_o  = m_wdata_i;
          s_mem_wstrb_o  = m_wstrb_i;
          s_mem_wvalid_o = m_wvalid_i;
          m_wready_o     = s_mem_wready_i;
        end
        TGT_UART: begin
          s_uart_wdata_o  = m_wdata_i;
          s_uart_wstrb_o  = m_wstrb_i;
          s_uart_wvalid_o = m_wvalid_i;
          m_wready_o      = s_uart_wready_i;
        end
        default: m_wready_o = 1'b1;
      endcase
    end
    if (b_route) begin
      case (w_tgt_q)
        TGT_MEM: begin
          m_bvalid_o     = s_mem_bvalid_i;
          m_bresp_o      = s_mem_bresp_i;
          s_mem_bready_o = m_bready_i;
        end
        TGT_UART: begin
          m_bvalid_o      = s_uart_bvalid_i;
          m_bresp_o       = s_uart_bresp_i;
          s_uart_bready_o = m_bready_i;
        end
        default: begin
          m_bvalid_o = 1'b1;
          m_bresp_o  = RESP_DECERR;
        end
      endcase
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_tgt_d   = r_tgt_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_DATA;
          r_tgt_d   = ar_tgt;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          r_state_d = R_IDLE;
        end
      end
    endcase
  end

  // The target is captured at whichever of AW or W handshakes first
  always_comb begin
    w_state_d = w_state_q;
    w_tgt_d   = w_tgt_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs || w_hs) begin
          w_tgt_d = aw_tgt;
        end
        if (aw_hs && w_hs) begin
          w_state_d = W_RESP;
        end else if (aw_hs) begin
          w_state_d = W_DATA;
        end else if (w_hs) begin
          w_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        if (aw_hs) begin
          w_state_d = W_RESP;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (b_hs) begin
          w_state_d = W_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_tgt_q   <= TGT_MEM;
      w_state_q <= W_IDLE;
      w_tgt_q   <= TGT_MEM;
    end else begin
      r_state_q <= r_state_d;
      r_tgt_q   <= r_tgt_d;
      w_state_q <= w_state_d;
      w_tgt_q   <= w_tgt_d;
    end
  end

endmodule

// File: tb/tb_axi_xbar_1to2.sv
// Directed testbench for axi_xbar_1to2: AR decode table plus hand-written channel sequences.
// Expectations for unmapped addresses follow AXI_XBAR_DECERR_EN.
module tb_axi_xbar_1to2;
  import xbar_pkg::*;

`ifdef AXI_XBAR_DECERR_EN
  localparam bit DECERR = 1'b1;
`else
  localparam bit DECERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] mAwaddr, mWdata, mAraddr, mRdata;
  logic [3:0]  mWstrb;
  logic [1:0]  mBresp, mRresp;
  logic        mAwvalid, mAwready, mWvalid, mWready, mBvalid, mBready;
  logic        mArvalid, mArready, mRvalid, mRready;

  logic [31:0] sMemAwaddr, sMemWdata, sMemAraddr, sMemRdata;
  logic [3:0]  sMemWstrb;
  logic [1:0]  sMemBresp, sMemRresp;
  logic        sMemAwvalid, sMemAwready, sMemWvalid, sMemWready, sMemBvalid, sMemBready;
  logic        sMemArvalid, sMemArready, sMemRvalid, sMemRready;

  logic [31:0] sUartAwaddr, sUartWdata, sUartAraddr, sUartRdata;
  logic [3:0]  sUartWstrb;
  logic [1:0]  sUartBresp, sUartRresp;
  logic        sUartAwvalid, sUartAwready, sUartWvalid, sUartWready, sUartBvalid, sUartBready;
  logic        sUartArvalid, sUartArready, sUartRvalid, sUartRready;

  int checks = 0;
  int failures = 0;
  int memAwCnt = 0, memWCnt = 0, uartAwCnt = 0, uartWCnt = 0, masterBCnt = 0;

  axi_xbar_1to2 dut (
    .clk(clk), .rst(rst),
    .m_awaddr_i(mAwaddr), .m_awvalid_i(mAwvalid), .m_awready_o(mAwready),
    .m_wdata_i(mWdata), .m_wstrb_i(mWstrb), .m_wvalid_i(mWvalid), .m_wready_o(mWready),
    .m_bresp_o(mBresp), .m_bvalid_o(mBvalid), .m_bready_i(mBready),
    .m_araddr_i(mAraddr), .m_arvalid_i(mArvalid), .m_arready_o(mArready),
    .m_rdata_o(mRdata), .m_rresp_o(mRresp), .m_rvalid_o(mRvalid), .m_rready_i(mRready),
    .s_mem_awaddr_o(sMemAwaddr), .s_mem_awvalid_o(sMemAwvalid), .s_mem_awready_i(sMemAwready),
    .s_mem_wdata_o(sMemWdata), .s_mem_wstrb_o(sMemWstrb), .s_mem_wvalid_o(sMemWvalid),
    .s_mem_wready_i(sMemWready), .s_mem_bresp_i(sMemBresp), .s_mem_bvalid_i(sMemBvalid),
    .s_mem_bready_o(sMemBready), .s_mem_araddr_o(sMemAraddr), .s_mem_arvalid_o(sMemArvalid),
    .s_mem_arready_i(sMemArready), .s_mem_rdata_i(sMemRdata), .s_mem_rresp_i(sMemRresp),
    .s_mem_rvalid_i(sMemRvalid), .s_mem_rready_o(sMemRready),
    .s_uart_awaddr_o(sUartAwaddr), .s_uart_awvalid_o(sUartAwvalid), .s_uart_awready_i(sUartAwready),
    .s_uart_wdata_o(sUartWdata), .s_uart_wstrb_o(sUartWstrb), .s_uart_wvalid_o(sUartWvalid),
    .s_uart_wready_i(sUartWready), .s_uart_bresp_i(sUartBresp), .s_uart_bvalid_i(sUartBvalid),
    .s_uart_bready_o(sUartBready), .s_uart_araddr_o(sUartAraddr), .s_uart_arvalid_o(sUartArvalid),
    .s_uart_arready_i(sUartArready), .s_uart_rdata_i(sUartRdata), .s_uart_rresp_i(sUartRresp),
    .s_uart_rvalid_i(sUartRvalid), .s_uart_rready_o(sUartRready)
  );

  // Handshake counters seen at the active edge
  always @(posedge clk) begin
    if (!rst) begin
      if (sMemAwvalid && sMemAwready) memAwCnt++;
      if (sMemWvalid && sMemWready) memWCnt++;
      if (sUartAwvalid && sUartAwready) uartAwCnt++;
      if (sUartWvalid && sUartWready) uartWCnt++;
      if (mBvalid && mBready) masterBCnt++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [31:0] addr;
    logic        valid;
    logic        memRdy;
    logic        uartRdy;
    int          expTgt;
    logic        expReady;
  } arVec_t;

  arVec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    mAwaddr = '0; mAwvalid = 0; mWdata = '0; mWstrb = '0; mWvalid = 0; mBready = 0;
    mAraddr = '0; mArvalid = 0; mRready = 0;
    sMemAwready = 0; sMemWready = 0; sMemBresp = '0; sMemBvalid = 0;
    sMemArready = 0; sMemRdata = '0; sMemRresp = '0; sMemRvalid = 0;
    sUartAwready = 0; sUartWready = 0; sUartBresp = '0; sUartBvalid = 0;
    sUartArready = 0; sUartRdata = '0; sUartRresp = '0; sUartRvalid = 0;
  endtask

  task automatic applyStimulus(input arVec_t v);
    mAraddr     = v.addr;
    mArvalid    = v.valid;
    sMemArready = v.memRdy;
    sUartArready = v.uartRdy;
  endtask

  int b0, mAw0, mW0, uAw0, uW0;

  initial begin
    vecs[0] = '{32'h80000100, 1'b1, 1'b1, 1'b0, 0, 1'b1};
    vecs[1] = '{32'ha00003f8, 1'b1, 1'b0, 1'b1, 1, 1'b1};
    vecs[2] = '{32'ha00003ff, 1'b1, 1'b1, 1'b0, 1, 1'b0};
    vecs[3] = '{32'ha0000400, 1'b1, 1'b1, 1'b1, DECERR ? 2 : 0, 1'b1};
    vecs[4] = '{32'ha00003f7, 1'b1, 1'b0, 1'b1, DECERR ? 2 : 0, DECERR ? 1'b1 : 1'b0};
    vecs[5] = '{32'h87ffffff, 1'b1, 1'b1, 1'b0, 0, 1'b1};
    vecs[6] = '{32'h88000000, 1'b1, 1'b0, 1'b0, DECERR ? 2 : 0, DECERR ? 1'b1 : 1'b0};
    vecs[7] = '{32'ha00003f8, 1'b0, 1'b1, 1'b1, 1, 1'b1};

    // Reset: everything active on the inputs, all valids/readies must still be low
    idleInputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    mArvalid = 1; mAwvalid = 1; mWvalid = 1; mRready = 1; mBready = 1;
    sMemArready = 1; sMemAwready = 1; sMemWready = 1; sMemRvalid = 1; sMemBvalid = 1;
    #1;
    checkOutput("reset_handshake_outputs",
                {16'b0, sMemAwvalid, sMemWvalid, sMemArvalid, sUartAwvalid, sUartWvalid, sUartArvalid,
                 mBvalid, mRvalid, mAwready, mWready, mArready, sMemBready, sMemRready,
                 sUartBready, sUartRready, 1'b0}, 32'h0);
    idleInputs();
    @(negedge clk);
    rst = 1'b0;

    // AR decode/routing table in R_IDLE; valid dropped before each edge
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("ar_vec%0d_mem_arvalid", i), sMemArvalid, vecs[i].valid && vecs[i].expTgt == 0);
      checkOutput($sformatf("ar_vec%0d_uart_arvalid", i), sUartArvalid, vecs[i].valid && vecs[i].expTgt == 1);
      checkOutput($sformatf("ar_vec%0d_m_arready", i), mArready, vecs[i].expReady);
      checkOutput($sformatf("ar_vec%0d_mem_araddr", i), sMemAraddr, vecs[i].expTgt == 0 ? vecs[i].addr : 32'h0);
      checkOutput($sformatf("ar_vec%0d_uart_araddr", i), sUartAraddr, vecs[i].expTgt == 1 ? vecs[i].addr : 32'h0);
      mArvalid = 0;
    end
    @(negedge clk);
    idleInputs();

    // UART write with AW and W in the same cycle
    b0 = masterBCnt; mAw0 = memAwCnt; uAw0 = uartAwCnt; uW0 = uartWCnt;
    @(negedge clk);
    mAwaddr = 32'ha00003f8; mAwvalid = 1; mWdata = 32'h41; mWstrb = 4'b0001; mWvalid = 1;
    sUartAwready = 1; sUartWready = 1;
    #1;
    checkOutput("uartwr_aw_valid", sUartAwvalid, 1);
    checkOutput("uartwr_w_valid", sUartWvalid, 1);
    checkOutput("uartwr_wdata", sUartWdata, 32'h41);
    checkOutput("uartwr_wstrb", sUartWstrb, 4'b0001);
    checkOutput("uartwr_mem_quiet", {sMemAwvalid, sMemWvalid}, 0);
    checkOutput("uartwr_m_ready", {mAwready, mWready}, 2'b11);
    @(negedge clk);
    idleInputs();
    sUartBvalid = 1; sUartBresp = RESP_OKAY; mBready = 1;
    #1;
    checkOutput("uartwr_m_bvalid", mBvalid, 1);
    checkOutput("uartwr_m_bresp", mBresp, RESP_OKAY);
    checkOutput("uartwr_bready_route", {sUartBready, sMemBready}, 2'b10);
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("uartwr_bvalid_cleared", mBvalid, 0);
    checkOutput("uartwr_counts", {uartAwCnt - uAw0, uartWCnt - uW0, memAwCnt - mAw0, masterBCnt - b0},
                {32'd1, 32'd1, 32'd0, 32'd1});

    // Memory read answered three cycles after the AR handshake
    @(negedge clk);
    mAraddr = 32'h80000100; mArvalid = 1; sMemArready = 1;
    @(negedge clk);
    sMemArready = 0;
    mAraddr = 32'ha00003f8; mArvalid = 1; sUartArready = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("memrd_stall%0d", k), {mArready, sUartArvalid, mRvalid}, 0);
      @(negedge clk);
    end
    sMemRvalid = 1; sMemRdata = 32'hdeadbeef; sMemRresp = RESP_OKAY; mRready = 1;
    #1;
    checkOutput("memrd_rvalid", mRvalid, 1);
    checkOutput("memrd_rdata", mRdata, 32'hdeadbeef);
    checkOutput("memrd_rready_route", {sMemRready, sUartRready}, 2'b10);
    checkOutput("memrd_arready_rdata", mArready, 0);
    @(negedge clk);
    sMemRvalid = 0; mRready = 0;
    #1;
    checkOutput("memrd_next_ar_accept", {mArready, sUartArvalid}, 2'b11);
    mArvalid = 0;
    @(negedge clk);
    idleInputs();

    // W presented two cycles before AW to memory
    b0 = masterBCnt; mAw0 = memAwCnt; mW0 = memWCnt;
    @(negedge clk);
    mWvalid = 1; mWdata = 32'h12345678; mWstrb = 4'hf; sMemWready = 1; sMemAwready = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checkOutput($sformatf("wfirst_hold%0d", k), {mWready, sMemWvalid}, 0);
      @(negedge clk);
    end
    mAwaddr = 32'h80000000; mAwvalid = 1;
    #1;
    checkOutput("wfirst_both_valid", {sMemAwvalid, sMemWvalid, mAwready, mWready}, 4'hf);
    checkOutput("wfirst_wdata", sMemWdata, 32'h12345678);
    @(negedge clk);
    idleInputs();
    sMemBvalid = 1; mBready = 1;
    #1;
    checkOutput("wfirst_bvalid", mBvalid, 1);
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("wfirst_counts", {memAwCnt - mAw0, memWCnt - mW0, masterBCnt - b0}, {32'd1, 32'd1, 32'd1});

    // Memory takes W first, AW two cycles later; new UART AW blocked during W_RESP
    b0 = masterBCnt; mAw0 = memAwCnt; mW0 = memWCnt; uAw0 = uartAwCnt;
    @(negedge clk);
    mAwaddr = 32'h80000010; mAwvalid = 1; mWvalid = 1; mWdata = 32'hcafef00d;
    sMemAwready = 0; sMemWready = 1;
    #1;
    checkOutput("wonly_ready", {mWready, mAwready}, 2'b10);
    @(negedge clk);
    mWvalid = 0;
    #1;
    checkOutput("waddr_route", {sMemAwvalid, sMemWvalid, mWready}, 3'b100);
    @(negedge clk);
    sMemAwready = 1;
    #1;
    checkOutput("waddr_aw_ready", mAwready, 1);
    @(negedge clk);
    sMemAwready = 0;
    mAwaddr = 32'ha00003fc; mAwvalid = 1; sUartAwready = 1;
    sMemBvalid = 1; mBready = 1;
    #1;
    checkOutput("wresp_blocks_aw", {mAwready, sUartAwvalid}, 0);
    checkOutput("wresp_bvalid", mBvalid, 1);
    @(negedge clk);
    sMemBvalid = 0; mBready = 0;
    #1;
    checkOutput("after_b_aw_accept", {mAwready, sUartAwvalid}, 2'b11);
    mAwvalid = 0;
    @(negedge clk);
    idleInputs();
    checkOutput("waddr_counts", {memAwCnt - mAw0, memWCnt - mW0, masterBCnt - b0, uartAwCnt - uAw0},
                {32'd1, 32'd1, 32'd1, 32'd0});

    // Concurrent memory read and UART write with decoy responses on the other slaves
    @(negedge clk);
    mAraddr = 32'h80000004; mArvalid = 1; sMemArready = 1;
    mAwaddr = 32'ha00003f8; mAwvalid = 1; mWvalid = 1; mWdata = 32'h5a;
    sUartAwready = 1; sUartWready = 1;
    #1;
    checkOutput("conc_routes", {sMemArvalid, sUartArvalid, sUartAwvalid, sMemAwvalid}, 4'b1010);
    @(negedge clk);
    idleInputs();
    sMemRvalid = 1; sMemRdata = 32'h11111111; sMemRresp = RESP_OKAY;
    sUartRvalid = 1; sUartRdata = 32'hbadbad00; sUartRresp = RESP_SLVERR;
    sUartBvalid = 1; sUartBresp = RESP_SLVERR;
    sMemBvalid = 1; sMemBresp = 2'b01;
    mRready = 1; mBready = 1;
    #1;
    checkOutput("conc_r", {mRvalid, mRresp, mRdata}, {1'b1, RESP_OKAY, 32'h11111111});
    checkOutput("conc_b", {mBvalid, mBresp}, {1'b1, RESP_SLVERR});
    checkOutput("conc_readies", {sMemRready, sUartRready, sUartBready, sMemBready}, 4'b1010);
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("conc_done", {mRvalid, mBvalid}, 0);

    // Unmapped read
    @(negedge clk);
    mAraddr = 32'h00001000; mArvalid = 1; sMemArready = DECERR ? 1'b0 : 1'b1;
    #1;
    checkOutput("unmapped_ar_mem", {sMemArvalid, sUartArvalid}, DECERR ? 2'b00 : 2'b10);
    checkOutput("unmapped_arready", mArready, 1);
    @(negedge clk);
    idleInputs();
    if (!DECERR) begin
      sMemRvalid = 1; sMemRdata = 32'h5;
    end
    #1;
    checkOutput("unmapped_r", {mRvalid, mRresp, mRdata}, DECERR ? {1'b1, RESP_DECERR, 32'h0} : {1'b1, RESP_OKAY, 32'h5});
    @(negedge clk);
    #1;
    checkOutput("unmapped_r_held", mRvalid, 1);
    mRready = 1;
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("unmapped_r_done", mRvalid, 0);

    // Reset pulsed during R_DATA abandons the read
    @(negedge clk);
    mAraddr = 32'h80000008; mArvalid = 1; sMemArready = 1;
    @(negedge clk);
    idleInputs();
    sMemRvalid = 1; sMemRdata = 32'h77;
    #1;
    checkOutput("rst_pre_rvalid", mRvalid, 1);
    rst = 1'b1;
    idleInputs();
    @(negedge clk);
    rst = 1'b0;
    sMemArready = 1;
    #1;
    checkOutput("rst_post_state", {mRvalid, mArready}, 2'b01);
    @(negedge clk);
    idleInputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
